// File: rtl/udma_eth_frame_pkg.sv
// Shared definitions for the uDMA Ethernet frame path: framer state encoding and
// default frame-length geometry.
package udma_eth_frame_pkg;

   localparam int ETH_LEN_WIDTH = 11;
   localparam int ETH_MIN_LEN   = 60;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS  = 2'd1,
      ST_PAD   = 2'd2,
      ST_ABORT = 2'd3
   } tx_state_e;

endpackage

// File: rtl/udma_eth_tx_framer.sv
// TX framer: zero-latency byte pass-through for len bytes, zero pad up to MIN_LEN,
// optional abort beat; never withdraws a presented beat, stalls with m_ready_i.
module udma_eth_tx_framer
   import udma_eth_frame_pkg::*;
#(
   parameter int LEN_WIDTH = ETH_LEN_WIDTH,
   parameter int MIN_LEN   = ETH_MIN_LEN
)(
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [LEN_WIDTH-1:0] cfg_len_i,
   input  logic                 cfg_start_i,
   input  logic                 cfg_abort_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [15:0]          frame_cnt_o,
   input  logic [7:0]           s_data_i,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
   output logic [7:0]           m_data_o,
   output logic                 m_valid_o,
   output logic                 m_last_o,
   output logic                 m_user_o,
   input  logic                 m_ready_i
);

   localparam logic [LEN_WIDTH-1:0] MIN_LEN_W = LEN_WIDTH'(MIN_LEN);
   localparam logic [LEN_WIDTH-1:0] ONE_W     = LEN_WIDTH'(1);

   tx_state_e            r_state;
   tx_state_e            w_state_nxt;
   logic [LEN_WIDTH-1:0] r_len;
   logic [LEN_WIDTH-1:0] r_cnt;
   logic                 r_abort;
   logic                 r_done;
   logic                 r_err;
   logic [15:0]          r_frame_cnt;

   logic [LEN_WIDTH-1:0] w_target;
   logic [LEN_WIDTH-1:0] w_target_m1;
   logic [LEN_WIDTH-1:0] w_len_m1;
   logic                 w_abort_req;
   logic                 w_beat;
   logic                 w_start_ok;
   logic                 w_start_err;
   logic                 w_frame_done;
   logic                 w_abort_set;

   assign w_target    = (r_len > MIN_LEN_W) ? r_len : MIN_LEN_W;
   assign w_target_m1 = w_target - ONE_W;
   assign w_len_m1    = r_len - ONE_W;
   assign w_abort_req = cfg_abort_i | r_abort;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      s_ready_o    = 1'b0;
      m_valid_o    = 1'b0;
      m_data_o     = 8'h00;
      m_last_o     = 1'b0;
      m_user_o     = 1'b0;
      w_start_ok   = 1'b0;
      w_start_err  = 1'b0;
      w_frame_done = 1'b0;
      w_abort_set  = 1'b0;
      w_beat       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (cfg_start_i) begin
               if (cfg_len_i != '0) begin
                  w_start_ok  = 1'b1;
                  w_state_nxt = ST_PASS;
               end else begin
                  w_start_err = 1'b1;
               end
            end
         end
         ST_PASS: begin
            m_data_o  = s_data_i;
            m_valid_o = s_valid_i;
            s_ready_o = m_ready_i;
            m_last_o  = (r_cnt == w_target_m1);
         end
         ST_PAD: begin
            m_valid_o = 1'b1;
            m_last_o  = (r_cnt == w_target_m1);
         end
         ST_ABORT: begin
            m_valid_o = 1'b1;
            m_last_o  = 1'b1;
            m_user_o  = 1'b1;
            if (m_ready_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // A natural last handshake wins over any pending abort; otherwise the abort
      // waits until the presented beat has been taken (or none is presented).
      if (r_state == ST_PASS || r_state == ST_PAD) begin
         w_beat = m_valid_o & m_ready_i;
         if (w_beat && m_last_o) begin
            w_frame_done = 1'b1;
            w_state_nxt  = ST_IDLE;
         end else if (w_abort_req && (w_beat || !m_valid_o)) begin
            w_state_nxt = ST_ABORT;
         end else if (w_abort_req) begin
            w_abort_set = 1'b1;
         end else if (w_beat && r_state == ST_PASS && r_cnt == w_len_m1) begin
            w_state_nxt = ST_PAD;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_len       <= '0;
         r_cnt       <= '0;
         r_abort     <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_frame_cnt <= 16'h0000;
      end else begin
         r_done  <= w_frame_done;
         r_err   <= w_start_err;
         r_abort <= w_abort_set;
         if (w_start_ok) begin
            r_len <= cfg_len_i;
            r_cnt <= '0;
         end else if (w_beat) begin
            r_cnt <= r_cnt + ONE_W;
         end
         if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign busy_o      = (r_state != ST_IDLE);
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_udma_eth_tx_framer.sv
// Randomized bench for udma_eth_tx_framer: expected byte streams come from a frame
// model (len source bytes, zero pad to max(len,60), optional abort beat).
module tb_udma_eth_tx_framer;

   localparam int MINL = 60;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic [10:0] cfg_len_i;
   logic        cfg_start_i;
   logic        cfg_abort_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [15:0] frame_cnt_o;
   logic [7:0]  s_data_i;
   logic        s_valid_i;
   logic        s_ready_o;
   logic [7:0]  m_data_o;
   logic        m_valid_o;
   logic        m_last_o;
   logic        m_user_o;
   logic        m_ready_i;

   udma_eth_tx_framer dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .cfg_len_i   (cfg_len_i),
      .cfg_start_i (cfg_start_i),
      .cfg_abort_i (cfg_abort_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .frame_cnt_o (frame_cnt_o),
      .s_data_i    (s_data_i),
      .s_valid_i   (s_valid_i),
      .s_ready_o   (s_ready_o),
      .m_data_o    (m_data_o),
      .m_valid_o   (m_valid_o),
      .m_last_o    (m_last_o),
      .m_user_o    (m_user_o),
      .m_ready_i   (m_ready_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   logic [7:0] src_mem [0:4095];
   int         src_idx = 0;
   int         src_hs, done_cnt, err_cnt, tick_no, first_beat, last_beat_tick;
   int         exp_frame_cnt = 0;
   bit         hold_vld = 1'b0;
   logic [7:0] hold_dat = 8'h00;
   bit         src_hold = 1'b0;
   logic [7:0] out_dat [$];
   bit         out_last [$];
   bit         out_user [$];

   // One clock cycle: drive at the falling edge, sample 2 time units later.
   task automatic tick(input bit v, input bit r, input bit st, input logic [10:0] ln, input bit ab);
      s_valid_i   = v;
      s_data_i    = src_mem[src_idx % 4096];
      m_ready_i   = r;
      cfg_start_i = st;
      cfg_len_i   = ln;
      cfg_abort_i = ab;
      #2;
      if (hold_vld) begin
         checks++;
         if (m_valid_o !== 1'b1 || m_data_o !== hold_dat) begin
            errors++;
            $display("FAIL beat_hold: valid=%b data=%h, required valid=1 data=%h", m_valid_o, m_data_o, hold_dat);
         end
      end
      hold_vld = (m_valid_o === 1'b1) && !r;
      hold_dat = m_data_o;
      src_hold = v && (s_ready_o !== 1'b1);
      if (m_valid_o === 1'b1 && r) begin
         out_dat.push_back(m_data_o);
         out_last.push_back(m_last_o === 1'b1);
         out_user.push_back(m_user_o === 1'b1);
         if (first_beat < 0) first_beat = tick_no;
         last_beat_tick = tick_no;
      end
      if (v && s_ready_o === 1'b1) begin
         src_idx++;
         src_hs++;
      end
      if (done_o === 1'b1) done_cnt++;
      if (err_o === 1'b1) err_cnt++;
      tick_no++;
      @(negedge clk_i);
   endtask

   task automatic clear_obs();
      out_dat.delete();
      out_last.delete();
      out_user.delete();
      src_hs = 0; done_cnt = 0; err_cnt = 0; tick_no = 0;
      first_beat = -1; last_beat_tick = -1; src_hold = 1'b0;
   endtask

   // rpct < 0 toggles sink ready every cycle. abort_at: abort is pulsed while the
   // (abort_at+1)-th beat is presented; abort_stall holds that beat with ready=0.
   task automatic run_frame(input string nm, input int len, input int vpct, input int rpct,
                            input int abort_at, input bit abort_stall, input int start2_at,
                            input bit full_rate);
      int tgt, s0, n_exp, bad_i, budget, exp_src;
      bit aborted, ab_done, st_done, v, r, st, ab;
      logic [7:0] e_dat;
      bit e_last, e_user;
      clear_obs();
      s0      = src_idx;
      tgt     = (len > MINL) ? len : MINL;
      aborted = (abort_at >= 0) && (abort_at + 1 < tgt);
      n_exp   = aborted ? abort_at + 2 : tgt;
      exp_src = aborted ? ((abort_at + 1 < len) ? abort_at + 1 : len) : len;
      ab_done = 1'b0; st_done = 1'b0;
      tick(1'b0, 1'b0, 1'b1, 11'(len), 1'b0);
      budget = 0;
      while (!(out_last.size() > 0 && out_last[out_last.size()-1]) && budget < 4000) begin
         v  = ($urandom_range(99) < vpct) || src_hold;
         r  = (rpct < 0) ? (tick_no % 2 == 1) : ($urandom_range(99) < rpct);
         st = 1'b0; ab = 1'b0;
         if (!ab_done && out_dat.size() == abort_at) begin
            ab = 1'b1; v = 1'b1; r = !abort_stall; ab_done = 1'b1;
         end
         if (!st_done && out_dat.size() == start2_at) begin
            st = 1'b1; st_done = 1'b1;
         end
         tick(v, r, st, st ? 11'd5 : 11'(len), ab);
         budget++;
      end
      checks++;
      if (budget >= 4000) begin
         errors++;
         $display("FAIL %s timeout: beats=%0d, required last beat within 4000 cycles", nm, out_dat.size());
      end
      repeat (3) tick(1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
      if (!aborted) exp_frame_cnt = (exp_frame_cnt + 1) % 65536;

      checks++;
      if (out_dat.size() != n_exp) begin
         errors++;
         $display("FAIL %s beat_count: got %0d, required %0d", nm, out_dat.size(), n_exp);
      end
      bad_i = -1;
      for (int i = 0; i < out_dat.size() && i < n_exp; i++) begin
         if (aborted && i == abort_at + 1) begin
            e_dat = 8'h00; e_last = 1'b1; e_user = 1'b1;
         end else begin
            e_dat  = (i < len) ? src_mem[(s0 + i) % 4096] : 8'h00;
            e_last = (i == tgt - 1);
            e_user = 1'b0;
         end
         if (bad_i < 0 && (out_dat[i] !== e_dat || out_last[i] != e_last || out_user[i] != e_user)) begin
            bad_i = i;
            $display("FAIL %s beat[%0d]: got data=%h last=%b user=%b, required data=%h last=%b user=%b",
                     nm, i, out_dat[i], out_last[i], out_user[i], e_dat, e_last, e_user);
         end
      end
      checks++;
      if (bad_i >= 0) errors++;
      checks++;
      if (src_hs != exp_src) begin
         errors++;
         $display("FAIL %s source_handshakes: got %0d, required %0d", nm, src_hs, exp_src);
      end
      checks++;
      if (done_cnt != (aborted ? 0 : 1) || err_cnt != 0) begin
         errors++;
         $display("FAIL %s done_err: got done=%0d err=%0d, required done=%0d err=0", nm, done_cnt, err_cnt, aborted ? 0 : 1);
      end
      checks++;
      if (frame_cnt_o !== 16'(exp_frame_cnt) || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s frame_cnt_busy: got cnt=%0d busy=%b, required cnt=%0d busy=0", nm, frame_cnt_o, busy_o, exp_frame_cnt);
      end
      if (full_rate) begin
         checks++;
         if (first_beat != 1 || last_beat_tick - first_beat + 1 != n_exp) begin
            errors++;
            $display("FAIL %s rate: first beat cycle %0d span %0d, required 1 and %0d", nm, first_beat, last_beat_tick - first_beat + 1, n_exp);
         end
      end
   endtask

   task automatic check_idle_outputs(input string nm, input logic [15:0] cnt);
      checks++;
      if ({busy_o, done_o, err_o, s_ready_o, m_valid_o, m_last_o, m_user_o} !== 7'b0 ||
          m_data_o !== 8'h00 || frame_cnt_o !== cnt) begin
         errors++;
         $display("FAIL %s: got busy=%b done=%b err=%b s_rdy=%b m_vld=%b last=%b user=%b data=%h cnt=%0d, required all 0 cnt=%0d",
                  nm, busy_o, done_o, err_o, s_ready_o, m_valid_o, m_last_o, m_user_o, m_data_o, frame_cnt_o, cnt);
      end
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      s_valid_i = 1'b1; m_ready_i = 1'b1; cfg_start_i = 1'b0; cfg_abort_i = 1'b0;
      cfg_len_i = 11'd0; s_data_i = 8'hA5;
      repeat (2) @(negedge clk_i);
      check_idle_outputs("reset_state", 16'd0);
      rstn_i = 1'b1;
      s_valid_i = 1'b0; m_ready_i = 1'b0;
      @(negedge clk_i);
      check_idle_outputs("after_release", 16'd0);
   endtask

   task automatic test_full_rate();
      run_frame("len64_full", 64, 100, 100, -1, 1'b0, -1, 1'b1);
   endtask

   task automatic test_pad();
      run_frame("len10_pad", 10, 100, 100, -1, 1'b0, -1, 1'b1);
      run_frame("len60_exact", 60, 100, 100, -1, 1'b0, -1, 1'b1);
   endtask

   task automatic test_len_zero();
      clear_obs();
      tick(1'b1, 1'b1, 1'b1, 11'd0, 1'b0);
      #1;
      checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL len0_err: got err=%b busy=%b, required err=1 busy=0", err_o, busy_o);
      end
      tick(1'b1, 1'b1, 1'b0, 11'd0, 1'b1);
      repeat (4) tick(1'b1, 1'b1, 1'b0, 11'd0, 1'b0);
      checks++;
      if (err_cnt != 1 || out_dat.size() != 0 || src_hs != 0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL len0_quiet: got err_pulses=%0d beats=%0d src=%0d busy=%b, required 1 0 0 0",
                  err_cnt, out_dat.size(), src_hs, busy_o);
      end
   endtask

   task automatic test_second_start();
      run_frame("second_start", 64, 80, 70, -1, 1'b0, 30, 1'b0);
   endtask

   task automatic test_abort();
      run_frame("abort_beat40", 100, 100, -1, 39, 1'b1, -1, 1'b0);
      run_frame("abort_on_last", 64, 100, 100, 63, 1'b0, -1, 1'b0);
      run_frame("abort_in_pad", 20, 90, 60, 35, 1'b0, -1, 1'b0);
   endtask

   task automatic test_random();
      int lens [6] = '{1, 59, 61, 0, 0, 0};
      int ln, ab;
      for (int f = 0; f < 6; f++) begin
         ln = (lens[f] != 0) ? lens[f] : int'($urandom_range(130, 1));
         ab = ($urandom_range(2) == 0) ? int'($urandom_range(((ln > MINL) ? ln : MINL) - 1)) : -1;
         run_frame($sformatf("random%0d", f), ln, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                   ab, 1'($urandom_range(1)), -1, 1'b0);
      end
   endtask

   task automatic test_reset_mid_pad();
      int budget = 0;
      clear_obs();
      tick(1'b0, 1'b0, 1'b1, 11'd10, 1'b0);
      while (out_dat.size() < 20 && budget < 200) begin
         tick(1'b1, 1'b1, 1'b0, 11'd10, 1'b0);
         budget++;
      end
      m_ready_i = 1'b1;
      #1;
      rstn_i = 1'b0;
      #1;
      check_idle_outputs("reset_mid_pad", 16'd0);
      exp_frame_cnt = 0;
      hold_vld = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      run_frame("len60_after_reset", 60, 100, 100, -1, 1'b0, -1, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) src_mem[i] = 8'($urandom);
      test_reset();
      test_full_rate();
      test_pad();
      test_len_zero();
      test_second_start();
      test_abort();
      test_random();
      test_reset_mid_pad();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion earlier");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/udma_eth_tx_framer.md
UDMA_ETH_TX_FRAMER -- requirements
Module: udma_eth_tx_framer

Interface
REQ-001 Parameter LEN_WIDTH, default 11, SHALL set the width of the frame length and byte counter.
REQ-002 Parameter MIN_LEN, default 60, SHALL be the minimum emitted frame length in bytes (pad target).
REQ-003 Ports SHALL be, in order:
- clk_i  in  1  single clock (uDMA sys clock)
- rstn_i  in  1  asynchronous active-low reset
- cfg_len_i  in  LEN_WIDTH  frame payload length in bytes
- cfg_start_i  in  1  one-cycle start pulse; samples cfg_len_i
- cfg_abort_i  in  1  one-cycle abort request
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse, frame completed
- err_o  out  1  one-cycle pulse, start rejected
- frame_cnt_o  out  16  completed-frame counter
- s_data_i  in  8  byte from TX buffer FIFO
- s_valid_i  in  1  source valid
- s_ready_o  out  1  source ready
- m_data_o  out  8  byte to TX dual-clock FIFO
- m_valid_o  out  1  sink valid
- m_last_o  out  1  last byte of frame
- m_user_o  out  1  frame aborted marker (on last beat)
- m_ready_i  in  1  sink ready
REQ-004 The block SHALL use one clock, clk_i, and an asynchronous active-low reset, rstn_i.

Function
REQ-005 States SHALL be IDLE, PASS, PAD, ABORT; encoding from the shared package.
REQ-006 IDLE: s_ready_o=0, m_valid_o=0; cfg_start_i with cfg_len_i!=0 SHALL latch len, clear byte_cnt, go to PASS next cycle.
REQ-007 cfg_start_i with cfg_len_i==0 SHALL pulse err_o the next cycle and stay IDLE.
REQ-008 cfg_start_i outside IDLE SHALL be ignored (no err_o, no state change).
REQ-009 PASS: zero-latency pass-through: m_data_o=s_data_i, m_valid_o=s_valid_i, s_ready_o=m_ready_i.
REQ-010 Each m_valid_o&m_ready_i handshake SHALL increment byte_cnt by 1.
REQ-011 target = max(len, MIN_LEN); m_last_o SHALL be 1 exactly on the beat where byte_cnt==target-1.
REQ-012 PASS beat with byte_cnt==len-1: if len>=MIN_LEN it is the last beat, go IDLE; else go PAD.
REQ-013 PAD: s_ready_o=0, m_valid_o=1, m_data_o=8'h00 until the beat with byte_cnt==target-1 is accepted, then IDLE.
REQ-014 Last-beat acceptance SHALL pulse done_o and increment frame_cnt_o (wraps 16'hFFFF->0) in the same cycle edge.
REQ-015 Source bytes beyond len SHALL NOT be consumed (s_ready_o=0 outside PASS).
REQ-016 cfg_abort_i in PASS/PAD SHALL be latched; it takes effect at the first cycle with no beat pending (m_valid_o=0) or right after a handshake, entering ABORT; an AXIS beat once presented is never withdrawn.
REQ-017 ABORT: m_valid_o=1, m_data_o=0, m_last_o=1, m_user_o=1 until accepted, then IDLE; no done_o, frame_cnt_o unchanged.
REQ-018 Abort coinciding with the natural last handshake SHALL be discarded; frame completes normally.
REQ-019 cfg_abort_i in IDLE SHALL be ignored.
REQ-020 m_user_o SHALL be 0 in all states except ABORT.
REQ-021 busy_o SHALL be 1 in PASS, PAD, ABORT; 0 in IDLE.
REQ-022 byte_cnt width is LEN_WIDTH; len > 2^LEN_WIDTH-1 is unrepresentable; no overflow handling needed.

Reset
REQ-023 rstn_i low SHALL force IDLE, byte_cnt=0, len=0, abort latch=0, frame_cnt_o=0, and all outputs 0, asynchronously.
REQ-024 Reset mid-frame SHALL drop the frame without emitting a last beat; downstream FIFO cleanup is out of scope.

Structure
REQ-025 Shared package udma_eth_frame_pkg SHALL hold the state enum, MIN_LEN default, and LEN_WIDTH default.
REQ-026 Single flat module; no sub-module; instantiated in udma_eth_frame between io_tx_fifo and the TX dual-clock FIFO.

Verification
REQ-027 len=64, source always valid, sink always ready -> 64 beats in 64 cycles, m_last_o on beat 64, done_o once, frame_cnt_o=1.
REQ-028 len=10 -> 10 source bytes then 50 bytes 8'h00, m_last_o on beat 60, exactly 10 source handshakes.
REQ-029 len=0 start -> err_o pulse next cycle, busy_o stays 0, no beats.
REQ-030 len=100, sink ready toggled every cycle, abort at beat 40 while valid&!ready -> beat 40 held and delivered, then one beat data=0 last=1 user=1, no done_o.
REQ-031 Second start during frame with len=5 -> ignored; first frame len=64 completes unchanged.
REQ-032 rstn_i asserted mid-PAD -> all outputs 0 immediately, next start len=60 behaves as REQ-027 with 60 beats.
